// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM port among N_REQ requesters
// Optional RAM wait watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_port_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 22,
    parameter int TIMEOUT = 255,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          WE,
    input  logic [N_REQ*ADDR_W-1:0]   ADDR,
    input  logic [N_REQ*8-1:0]        WDATA,
    output logic [N_REQ-1:0]          ACK,
    output logic [7:0]                RDATA,
    output logic                      ERR,
    output logic                      BUSY,
    output logic [ID_W-1:0]           GRANT_ID,
    output logic                      RAM_REQ,
    output logic                      RAM_WE,
    output logic [ADDR_W-1:0]         RAM_ADDR,
    output logic [7:0]                RAM_WDATA,
    input  logic                      RAM_ACK,
    input  logic [7:0]                RAM_RDATA
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("ram_port_arbiter: N_REQ must be 2..8 and TIMEOUT 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            any_req;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        win     = ptr;
        cand    = ptr;
        any_req = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!any_req && REQ[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            ACK       <= '0;
            RDATA     <= 8'h00;
            BUSY      <= 1'b0;
            GRANT_ID  <= '0;
            RAM_REQ   <= 1'b0;
            RAM_WE    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            ERR       <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ACK <= '0;
`ifdef ARB_TIMEOUT_EN
                    ERR <= 1'b0;
`endif
                    if (any_req) begin
                        RAM_WE    <= WE[win];
                        RAM_ADDR  <= ADDR[int'(win)*ADDR_W +: ADDR_W];
                        RAM_WDATA <= WDATA[int'(win)*8 +: 8];
                        GRANT_ID  <= win;
                        ptr       <= win;
                        RAM_REQ   <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= S_ISSUE;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (RAM_ACK) begin
                        if (!RAM_WE) begin
                            RDATA <= RAM_RDATA;
                        end
                        RAM_REQ <= 1'b0;
                        ACK     <= N_REQ'(1) << GRANT_ID;
                        state   <= S_DONE;
`ifdef ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // The command is abandoned; the owner sees an error completion.
                        RDATA   <= 8'hFF;
                        ERR     <= 1'b1;
                        RAM_REQ <= 1'b0;
                        ACK     <= N_REQ'(1) << GRANT_ID;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    ACK   <= '0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
                    ERR   <= 1'b0;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter (timeout cases under ARB_TIMEOUT_EN)
module tb_ram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 22;

    logic              CLK = 1'b0;
    logic              RESET_n;
    logic [N-1:0]      REQ, WE, ACK;
    logic [N*AW-1:0]   ADDR;
    logic [N*8-1:0]    WDATA;
    logic [7:0]        RDATA, RAM_WDATA, RAM_RDATA;
    logic              ERR, BUSY, RAM_REQ, RAM_WE, RAM_ACK;
    logic [1:0]        GRANT_ID;
    logic [AW-1:0]     RAM_ADDR;

    int checks = 0;
    int errors = 0;
    int last_id;
    logic [7:0] mdl_rdata;

    always #5 CLK = ~CLK;

    ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY), .GRANT_ID(GRANT_ID),
        .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA)
    );

    typedef struct {
        logic [N-1:0]         req;
        logic [N-1:0]         we;
        logic [N-1:0][AW-1:0] addr;
        logic [N-1:0][7:0]    wdata;
        int                   lat;
        logic [7:0]           rd;
        int                   exp_id;
        logic [7:0]           exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        REQ = '0;
        RAM_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        last_id = N - 1;
        mdl_rdata = 8'h00;
    endtask

    // One complete transaction; RAM_ACK is returned in ISSUE cycle lat+1.
    task automatic do_txn(input logic [N-1:0] req, input logic [N-1:0] we,
                          input logic [N*AW-1:0] addr, input logic [N*8-1:0] wd,
                          input int lat, input logic [7:0] rd,
                          input int exp_id, input logic [7:0] exp_rd);
        logic [AW-1:0] ea;
        logic [7:0]    ew;
        logic          ewe;
        logic [N-1:0]  eack;
        ea  = addr[exp_id*AW +: AW];
        ew  = wd[exp_id*8 +: 8];
        ewe = we[exp_id];
        eack = '0;
        eack[exp_id] = 1'b1;
        @(negedge CLK);
        REQ = req; WE = we; ADDR = addr; WDATA = wd; RAM_ACK = 1'b0;
        @(negedge CLK);
        check("grant_ram_req", 32'(RAM_REQ), 32'd1);
        check("grant_id", 32'(GRANT_ID), 32'(exp_id));
        check("grant_busy", 32'(BUSY), 32'd1);
        check("cmd_we", 32'(RAM_WE), 32'(ewe));
        check("cmd_addr", 32'(RAM_ADDR), 32'(ea));
        check("cmd_wdata", 32'(RAM_WDATA), 32'(ew));
        WE = 3'($urandom);
        ADDR = {2'($urandom), $urandom, $urandom};
        WDATA = 24'($urandom);
        for (int c = 0; c < lat; c++) begin
            RAM_RDATA = 8'($urandom);
            @(negedge CLK);
            check("hold_ram_req", 32'(RAM_REQ), 32'd1);
            check("hold_addr", 32'(RAM_ADDR), 32'(ea));
            check("hold_we", 32'(RAM_WE), 32'(ewe));
            check("hold_wdata", 32'(RAM_WDATA), 32'(ew));
            check("hold_no_ack", 32'(ACK), 32'd0);
        end
        RAM_ACK = 1'b1;
        RAM_RDATA = rd;
        @(negedge CLK);
        check("done_ack", 32'(ACK), 32'(eack));
        check("done_rdata", 32'(RDATA), 32'(exp_rd));
        check("done_err", 32'(ERR), 32'd0);
        check("done_ram_req", 32'(RAM_REQ), 32'd0);
        check("done_busy", 32'(BUSY), 32'd1);
        RAM_ACK = 1'b0;
        REQ = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, icnt, n, exp, done;
        logic [N-1:0] r, w;
        logic [7:0] rd, erd;

        vecs[0] = '{3'b001, 3'b000, {22'h000333, 22'h000222, 22'h004000}, {8'h03, 8'h02, 8'h01}, 0, 8'hA5, 0, 8'hA5};
        vecs[1] = '{3'b010, 3'b010, {22'h2A0000, 22'h100000, 22'h0AAAAA}, {8'h77, 8'h3C, 8'h11}, 5, 8'h77, 1, 8'hA5};
        vecs[2] = '{3'b111, 3'b000, {22'h3FFFFF, 22'h155555, 22'h000001}, {8'h9A, 8'h8B, 8'h7C}, 1, 8'h5A, 2, 8'h5A};
        vecs[3] = '{3'b011, 3'b001, {22'h0F0F0F, 22'h200000, 22'h012345}, {8'h44, 8'h55, 8'h66}, 0, 8'h99, 0, 8'h5A};
        vecs[4] = '{3'b101, 3'b000, {22'h123456, 22'h234567, 22'h345678}, {8'hD1, 8'hD2, 8'hD3}, 3, 8'hC3, 2, 8'hC3};
        vecs[5] = '{3'b100, 3'b000, {22'h000010, 22'h000020, 22'h000030}, {8'hE1, 8'hE2, 8'hE3}, 0, 8'h0F, 2, 8'h0F};
        vecs[6] = '{3'b110, 3'b100, {22'h300001, 22'h0C0002, 22'h000003}, {8'hF7, 8'hF8, 8'hF9}, 2, 8'hE1, 1, 8'hE1};

        RESET_n = 1'b0; REQ = '0; WE = '0; ADDR = '0; WDATA = '0; RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_ram_req", 32'(RAM_REQ), 32'd0);
        check("rst_ram_we", 32'(RAM_WE), 32'd0);
        check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
        check("rst_ram_wdata", 32'(RAM_WDATA), 32'd0);
        check("rst_rdata", 32'(RDATA), 32'd0);
        check("rst_grant_id", 32'(GRANT_ID), 32'd0);
        RESET_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].lat, vecs[i].rd, vecs[i].exp_id, vecs[i].exp_rdata);

        // Spurious RAM_ACK while idle must be ignored.
        @(negedge CLK);
        REQ = '0; RAM_ACK = 1'b1; RAM_RDATA = 8'hEE;
        repeat (2) begin
            @(negedge CLK);
            check("spur_ack", 32'(ACK), 32'd0);
            check("spur_ram_req", 32'(RAM_REQ), 32'd0);
            check("spur_busy", 32'(BUSY), 32'd0);
            check("spur_rdata", 32'(RDATA), 32'hE1);
        end
        RAM_ACK = 1'b0;
        do_txn(3'b001, 3'b000, {22'h1, 22'h2, 22'h3}, 24'h0, 0, 8'h3B, 0, 8'h3B);

        // Continuous requests from everyone: strict rotation 0,1,2,0,1,2.
        do_reset();
        @(negedge CLK);
        REQ = 3'b111; WE = '0; ADDR = {22'h3, 22'h2, 22'h1};
        got = 0; icnt = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            @(negedge CLK);
            if (ACK != '0) begin
                check("fair_onehot", 32'($countones(ACK)), 32'd1);
                check("fair_ack", 32'(ACK), 32'(3'b001 << (got % 3)));
                check("fair_grant_id", 32'(GRANT_ID), 32'(got % 3));
                got++;
                if (got == 6) REQ = '0;
            end
            if (RAM_REQ) begin
                RAM_ACK = (icnt == 2);
                RAM_RDATA = 8'(8'h40 + got);
                icnt++;
            end else begin
                RAM_ACK = 1'b0;
                icnt = 0;
            end
        end
        RAM_ACK = 1'b0;
        check("fair_count", 32'(got), 32'd6);

        // Reset in ISSUE: outputs clear at once, requester 0 wins afterwards.
        @(negedge CLK);
        REQ = 3'b010; WE = '0;
        @(negedge CLK);
        check("rstmid_issue", 32'(RAM_REQ), 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("rstmid_ram_req", 32'(RAM_REQ), 32'd0);
        check("rstmid_busy", 32'(BUSY), 32'd0);
        check("rstmid_ack", 32'(ACK), 32'd0);
        REQ = 3'b111;
        @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        check("rstmid_regrant", 32'(RAM_REQ), 32'd1);
        check("rstmid_grant0", 32'(GRANT_ID), 32'd0);
        RAM_ACK = 1'b1; RAM_RDATA = 8'h21;
        @(negedge CLK);
        check("rstmid_ack0", 32'(ACK), 32'd1);
        RAM_ACK = 1'b0; REQ = '0;

        // Random traffic against a transaction-level round-robin model.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            r = 3'($urandom_range(1, 7));
            w = 3'($urandom);
            rd = 8'($urandom);
            exp = -1;
            for (int d = 1; d <= N; d++)
                if (exp < 0 && r[(last_id + d) % N]) exp = (last_id + d) % N;
            erd = w[exp] ? mdl_rdata : rd;
            do_txn(r, w, {2'($urandom), $urandom, $urandom}, 24'($urandom),
                   $urandom_range(0, 4), rd, exp, erd);
            last_id = exp;
            mdl_rdata = erd;
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

`ifdef ARB_TIMEOUT_EN
        do_reset();
        @(negedge CLK);
        REQ = 3'b010; WE = '0; RAM_ACK = 1'b0;
        n = 0; done = 0;
        for (int c = 0; c < 40 && done == 0; c++) begin
            @(negedge CLK);
            if (ACK != '0) done = 1;
            else if (RAM_REQ) n++;
        end
        check("to_done", 32'(done), 32'd1);
        check("to_issue_cycles", 32'(n), 32'd16);
        check("to_ack", 32'(ACK), 32'b010);
        check("to_err", 32'(ERR), 32'd1);
        check("to_rdata", 32'(RDATA), 32'hFF);
        check("to_ram_req", 32'(RAM_REQ), 32'd0);
        REQ = '0;
        do_txn(3'b001, 3'b000, {22'h7, 22'h8, 22'h9}, 24'h0, 15, 8'h12, 0, 8'h12);
        do_txn(3'b100, 3'b000, {22'h7, 22'h8, 22'h9}, 24'h0, 0, 8'h34, 2, 8'h34);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
